// File: rtl/hv_dac_sched_pkg.sv
// Shared types and constants for the HV DAC write scheduler.
// State encoding, SPI word layout and default limits live here.
package hv_dac_sched_pkg;

    localparam int CODE_W      = 10;
    localparam int DAC_W       = 16;
    localparam int CODE_LSB    = 2;
    localparam int DONE_TO_DEF = 4096;
    localparam int HV_MAX_DEF  = 1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SEND,
        S_WAIT_DONE,
        S_SETTLE
    } state_t;

    // SPI word: 4 pad bits, code, 2 pad bits.
    function automatic logic [DAC_W-1:0] dac_word(
        input logic [CODE_W-1:0] code
    );
        return {4'd0, code, 2'd0};
    endfunction

    function automatic logic [CODE_W-1:0] clamp_code(
        input logic [CODE_W-1:0] v,
        input int                max
    );
        if (int'(v) > max) return CODE_W'(max);
        return v;
    endfunction

endpackage

// File: rtl/hv_dac_sched_if.sv
// Request, DAC handshake and status bundle for hv_dac_sched.
// slave is the scheduler side, master the requester/DAC side.
interface hv_dac_sched_if;
    import hv_dac_sched_pkg::*;

    logic              i_comp_req;
    logic [CODE_W-1:0] i_comp_value;
    logic              i_host_req;
    logic [CODE_W-1:0] i_host_value;
    logic [CODE_W-1:0] i_step_max;
    logic [15:0]       i_settle_cyc;
    logic              i_dac_done;
    logic              o_comp_ack;
    logic              o_host_ack;
    logic              o_dac_start;
    logic [DAC_W-1:0]  o_dac_data;
    logic [CODE_W-1:0] o_dac_value;
    logic              o_busy;
    logic              o_timeout_err;

    modport slave (
        input  i_comp_req, i_comp_value,
        input  i_host_req, i_host_value,
        input  i_step_max, i_settle_cyc,
        input  i_dac_done,
        output o_comp_ack, o_host_ack,
        output o_dac_start, o_dac_data,
        output o_dac_value, o_busy,
        output o_timeout_err
    );

    modport master (
        output i_comp_req, i_comp_value,
        output i_host_req, i_host_value,
        output i_step_max, i_settle_cyc,
        output i_dac_done,
        input  o_comp_ack, o_host_ack,
        input  o_dac_start, o_dac_data,
        input  o_dac_value, o_busy,
        input  o_timeout_err
    );

endinterface

// File: rtl/hv_step_calc.sv
// Next DAC code toward target; slew limited when HV_DAC_RAMP_EN
// is defined, otherwise the target is written directly.
module hv_step_calc
    import hv_dac_sched_pkg::*;
#(
    parameter int HV_MAX = HV_MAX_DEF
) (
    input  logic [CODE_W-1:0] cur,
    input  logic [CODE_W-1:0] target,
    input  logic [CODE_W-1:0] step,
    output logic [CODE_W-1:0] next
);

`ifdef HV_DAC_RAMP_EN
    logic signed [CODE_W:0] diff;
    logic [CODE_W:0]        mag;
    logic [CODE_W-1:0]      stp;
    logic [CODE_W-1:0]      raw;

    // 11-bit signed difference keeps cur +/- stp inside 0..1023.
    always_comb begin
        stp  = (step == '0) ? CODE_W'(1) : step;
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        mag  = diff[CODE_W] ? unsigned'(-diff) : unsigned'(diff);
        if (mag <= {1'b0, stp}) begin
            raw = target;
        end else if (diff[CODE_W]) begin
            raw = cur - stp;
        end else begin
            raw = cur + stp;
        end
        next = clamp_code(raw, HV_MAX);
    end
`else
    logic unused;

    assign unused = ^{cur, step};
    assign next   = clamp_code(target, HV_MAX);
`endif

endmodule

// File: rtl/hv_dac_sched.sv
// HV DAC write scheduler: host/comp arbitration, ramp, settle, timeout.
// Slew limiting is enabled by defining HV_DAC_RAMP_EN.
module hv_dac_sched
    import hv_dac_sched_pkg::*;
#(
    parameter int DONE_TO = DONE_TO_DEF,
    parameter int HV_MAX  = HV_MAX_DEF
) (
    input logic           i_clk_50m,
    input logic           i_rst_n,
    hv_dac_sched_if.slave bus
);

    state_t            state;
    logic [CODE_W-1:0] target;
    logic [CODE_W-1:0] next_code;
    logic [CODE_W-1:0] calc_code;
    logic [31:0]       cnt;

    hv_step_calc #(
        .HV_MAX (HV_MAX)
    ) u_step (
        .cur    (bus.o_dac_value),
        .target (target),
        .step   (bus.i_step_max),
        .next   (calc_code)
    );

    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            state             <= S_IDLE;
            target            <= '0;
            next_code         <= '0;
            cnt               <= '0;
            bus.o_dac_value   <= '0;
            bus.o_dac_data    <= '0;
            bus.o_dac_start   <= 1'b0;
            bus.o_host_ack    <= 1'b0;
            bus.o_comp_ack    <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_timeout_err <= 1'b0;
        end else begin
            bus.o_dac_start <= 1'b0;
            bus.o_host_ack  <= 1'b0;
            bus.o_comp_ack  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // Host has priority; comp stays pending until next IDLE.
                    if (bus.i_host_req) begin
                        target         <= clamp_code(bus.i_host_value, HV_MAX);
                        bus.o_host_ack <= 1'b1;
                        bus.o_busy     <= 1'b1;
                        state          <= S_STEP;
                    end else if (bus.i_comp_req) begin
                        target         <= clamp_code(bus.i_comp_value, HV_MAX);
                        bus.o_comp_ack <= 1'b1;
                        bus.o_busy     <= 1'b1;
                        state          <= S_STEP;
                    end
                end
                S_STEP: begin
                    next_code       <= calc_code;
                    bus.o_dac_data  <= dac_word(calc_code);
                    bus.o_dac_start <= 1'b1;
                    state           <= S_SEND;
                end
                S_SEND: begin
                    cnt   <= '0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.i_dac_done) begin
                        bus.o_dac_value <= next_code;
                        cnt <= (bus.i_settle_cyc == '0) ? 32'd1
                                                        : {16'd0, bus.i_settle_cyc};
                        state <= S_SETTLE;
                    end else if (cnt == 32'(DONE_TO - 1)) begin
                        bus.o_timeout_err <= 1'b1;
                        bus.o_busy        <= 1'b0;
                        cnt               <= '0;
                        state             <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt <= 32'd1) begin
                        cnt <= '0;
                        if (bus.o_dac_value != target) begin
                            state <= S_STEP;
                        end else begin
                            bus.o_busy <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    bus.o_busy <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hv_dac_sched.sv
// Directed bench for hv_dac_sched; expected write sequences
// follow HV_DAC_RAMP_EN (step 100, settle 10, HV_MAX 1000).
module tb_hv_dac_sched;

    logic clk;
    logic rst_n;
    logic auto_done;
    logic man_done;
    logic dac_en;
    int   cyc;
    int   nwr;
    int   n_hack;
    int   n_cack;
    int   pend;
    int   wr_code [64];
    int   wr_cyc  [64];
    int   n_chk;
    int   n_err;

    hv_dac_sched_if bus ();

    assign bus.i_dac_done = auto_done | man_done;

    hv_dac_sched dut (
        .i_clk_50m (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, ack counters and a DAC that answers 3 cycles after start.
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (bus.o_dac_start) begin
            if (nwr < 64) begin
                wr_code[nwr] = int'(bus.o_dac_data[11:2]);
                wr_cyc[nwr]  = cyc;
            end
            nwr++;
            pend = dac_en ? 3 : 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) auto_done = 1'b1;
        end
        if (bus.o_host_ack) n_hack++;
        if (bus.o_comp_ack) n_cack++;
    end

`ifdef HV_DAC_RAMP_EN
    int e_t1 [$] = '{100, 200, 300, 350};
    int e_t2 [$] = '{250, 200, 300, 400, 500};
    int e_t3 [$] = '{600, 700, 800, 900, 1000};
    int e_t5 [$] = '{999, 998};
    int e_t6 [$] = '{898};
`else
    int e_t1 [$] = '{350};
    int e_t2 [$] = '{200, 500};
    int e_t3 [$] = '{1000};
    int e_t5 [$] = '{998};
    int e_t6 [$] = '{50};
`endif
    int e_t4 [$] = '{1000};
    int e_t7 [$] = '{990};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input bit host, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = host ? bus.o_host_ack : bus.o_comp_ack;
        end
        chk(tag, int'(got), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            tick();
            idle = !bus.o_busy;
        end
        chk(tag, int'(idle), 1);
    endtask

    task automatic host_write(input string tag, input int v, input int budget);
        bus.i_host_value = 10'(v);
        bus.i_host_req   = 1'b1;
        wait_ack({tag, "_hack"}, 1'b1, 10);
        bus.i_host_req = 1'b0;
        wait_idle({tag, "_idle"}, budget);
    endtask

    task automatic check_writes(input string tag, input int base, input int e[$]);
        chk({tag, "_nwr"}, nwr - base, e.size());
        for (int i = 0; i < e.size() && base + i < 64; i++) begin
            chk({tag, "_code"}, wr_code[base + i], e[i]);
        end
        for (int i = 1; i < e.size() && base + i < 64; i++) begin
            chk({tag, "_gap"}, int'(wr_cyc[base + i] - wr_cyc[base + i - 1] >= 11), 1);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_value"}, int'(bus.o_dac_value), 0);
        chk({tag, "_data"}, int'(bus.o_dac_data), 0);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
        chk({tag, "_start"}, int'(bus.o_dac_start), 0);
        chk({tag, "_acks"}, int'({bus.o_host_ack, bus.o_comp_ack}), 0);
        chk({tag, "_tout"}, int'(bus.o_timeout_err), 0);
    endtask

    initial begin
        int base;
        int h0;
        int c0;
        int t_idle;
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        nwr = 0;
        n_hack = 0;
        n_cack = 0;
        pend = 0;
        auto_done = 1'b0;
        man_done = 1'b0;
        dac_en = 1'b1;
        rst_n = 1'b0;
        bus.i_comp_req = 1'b0;
        bus.i_comp_value = '0;
        bus.i_host_req = 1'b0;
        bus.i_host_value = '0;
        bus.i_step_max = 10'd100;
        bus.i_settle_cyc = 16'd10;

        repeat (3) tick();
        check_reset_outs("reset");
        rst_n = 1'b1;
        tick();

        // Host 350 from 0
        base = nwr;
        h0 = n_hack;
        c0 = n_cack;
        host_write("t1", 350, 300);
        check_writes("t1", base, e_t1);
        chk("t1_value", int'(bus.o_dac_value), 350);
        chk("t1_data", int'(bus.o_dac_data), 'h578);
        chk("t1_nhack", n_hack - h0, 1);
        chk("t1_ncack", n_cack - c0, 0);

        // Simultaneous host 200 / comp 500: host first
        base = nwr;
        bus.i_host_value = 10'd200;
        bus.i_comp_value = 10'd500;
        bus.i_host_req = 1'b1;
        bus.i_comp_req = 1'b1;
        wait_ack("t2_hack", 1'b1, 10);
        chk("t2_comp_held", int'(bus.o_comp_ack), 0);
        bus.i_host_req = 1'b0;
        wait_ack("t2_cack", 1'b0, 300);
        chk("t2_val_at_cack", int'(bus.o_dac_value), 200);
        bus.i_comp_req = 1'b0;
        wait_idle("t2_idle", 300);
        check_writes("t2", base, e_t2);
        chk("t2_value", int'(bus.o_dac_value), 500);

        // 1023 clamps to HV_MAX
        base = nwr;
        host_write("t3", 1023, 400);
        check_writes("t3", base, e_t3);
        chk("t3_data", int'(bus.o_dac_data), 'h0FA0);
        chk("t3_value", int'(bus.o_dac_value), 1000);

        // Refresh at same code
        base = nwr;
        host_write("t4", 1000, 100);
        check_writes("t4", base, e_t4);

        // Step 0 behaves as step 1
        bus.i_step_max = 10'd0;
        base = nwr;
        host_write("t5", 998, 200);
        check_writes("t5", base, e_t5);
        chk("t5_value", int'(bus.o_dac_value), 998);
        bus.i_step_max = 10'd100;

        // Done withheld: timeout after DONE_TO cycles
        dac_en = 1'b0;
        base = nwr;
        host_write("t6", 50, 5000);
        t_idle = cyc;
        check_writes("t6", base, e_t6);
        chk("t6_latency", t_idle - wr_cyc[base], 4097);
        chk("t6_tout", int'(bus.o_timeout_err), 1);
        chk("t6_value", int'(bus.o_dac_value), 998);
        dac_en = 1'b1;

        // Flag is sticky across a good write
        base = nwr;
        host_write("t7", 990, 100);
        check_writes("t7", base, e_t7);
        chk("t7_tout", int'(bus.o_timeout_err), 1);
        chk("t7_value", int'(bus.o_dac_value), 990);

        // Reset in WAIT_DONE, then a stray done
        dac_en = 1'b0;
        base = nwr;
        bus.i_host_value = 10'd500;
        bus.i_host_req = 1'b1;
        wait_ack("t8_hack", 1'b1, 10);
        bus.i_host_req = 1'b0;
        for (int i = 0; i < 10 && nwr == base; i++) tick();
        chk("t8_started", nwr - base, 1);
        repeat (2) tick();
        chk("t8_busy_pre", int'(bus.o_busy), 1);
        rst_n = 1'b0;
        tick();
        check_reset_outs("t8_rst");
        rst_n = 1'b1;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (3) tick();
        check_reset_outs("t8_late");
        chk("t8_nwr", nwr - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hv_dac_sched.md
HV_DAC_SCHED -- requirements
Module: hv_dac_sched

Interface
REQ-001 SHALL have parameter DONE_TO, default 4096, meaning the number of cycles allowed for a DAC transfer to finish after start.
REQ-002 SHALL have parameter HV_MAX, default 1000, meaning the upper clamp applied to any requested DAC code.
REQ-003 SHALL have port i_clk_50m  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port i_comp_req  in  1  temperature-compensation write request; level, held until acknowledged.
REQ-006 SHALL have port i_comp_value  in  10  DAC code carried by the compensation request.
REQ-007 SHALL have port i_host_req  in  1  host/calibration write request; level, held until acknowledged.
REQ-008 SHALL have port i_host_value  in  10  DAC code carried by the host request.
REQ-009 SHALL have port i_step_max  in  10  maximum code change per write; 0 is treated as 1.
REQ-010 SHALL have port i_settle_cyc  in  16  idle cycles inserted after each completed write.
REQ-011 SHALL have port i_dac_done  in  1  one-cycle pulse from the DAC SPI engine when a transfer completes.
REQ-012 SHALL have port o_comp_ack  out  1  one-cycle pulse when the compensation request is accepted.
REQ-013 SHALL have port o_host_ack  out  1  one-cycle pulse when the host request is accepted.
REQ-014 SHALL have port o_dac_start  out  1  one-cycle transfer start to the DAC SPI engine.
REQ-015 SHALL have port o_dac_data  out  16  SPI word, {4'd0, code, 2'd0}.
REQ-016 SHALL have port o_dac_value  out  10  last code confirmed written.
REQ-017 SHALL have port o_busy  out  1  high whenever the block is not in IDLE.
REQ-018 SHALL have port o_timeout_err  out  1  sticky flag: a transfer did not complete within DONE_TO cycles.

Function
REQ-019 SHALL implement the states IDLE, STEP, SEND, WAIT_DONE and SETTLE.
REQ-020 IDLE: on i_host_req, latch min(i_host_value, HV_MAX) as target, pulse o_host_ack, go to STEP; else on i_comp_req, do the same with the compensation request and o_comp_ack.
REQ-021 On simultaneous requests the host SHALL win; the compensation request stays pending and is served on the next return to IDLE.
REQ-022 Requests arriving outside IDLE SHALL be neither acknowledged nor lost, since requesters hold them until acknowledged.
REQ-023 STEP: next code = target when |target - o_dac_value| <= step; otherwise o_dac_value +/- step toward target; go to SEND.
REQ-024 SEND: drive o_dac_start high for exactly one cycle with o_dac_data formed from the next code; go to WAIT_DONE.
REQ-025 WAIT_DONE, on i_dac_done: o_dac_value <= next code, reload the settle counter, go to SETTLE.
REQ-026 WAIT_DONE, after DONE_TO cycles without i_dac_done: set o_timeout_err, leave o_dac_value unchanged, go to IDLE.
REQ-027 SETTLE: count i_settle_cyc cycles (0 means one cycle); then go to STEP if o_dac_value != target, otherwise go to IDLE.
REQ-028 A target equal to o_dac_value SHALL still produce exactly one SPI write (refresh).
REQ-029 o_dac_data SHALL hold its value from SEND until the next SEND.
REQ-030 o_timeout_err SHALL clear only on reset.
REQ-031 Step arithmetic SHALL use 11-bit signed difference logic, so no wrap-around below 0 or above 1023.

Reset
REQ-032 On i_rst_n low at a clock edge: state IDLE, o_dac_value 0, o_dac_data 0, all acks and o_dac_start 0, o_busy 0, o_timeout_err 0, counters 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer; a late i_dac_done seen in IDLE SHALL be ignored.

Configuration
REQ-034 Macro HV_DAC_RAMP_EN defined: slew limiting per REQ-023.
REQ-035 Macro HV_DAC_RAMP_EN undefined: i_step_max is ignored, next code = target always, and each request produces exactly one write.

Structure
REQ-036 A shared package SHALL hold the state encoding, the DAC word field layout and the DONE_TO/HV_MAX defaults.
REQ-037 A sub-module hv_step_calc SHALL compute the clamped next code combinationally.

Verification
REQ-038 o_dac_value=0, step=100, settle=10, host_req value 350 -> four writes (100, 200, 300, 350), each separated by >=11 cycles, one host_ack, o_dac_value=350.
REQ-039 Both requests in the same cycle (host 200, comp 500) -> host_ack first, ramp to 200; comp_ack on the first IDLE cycle after, ramp to 500.
REQ-040 Host value 1023 with HV_MAX=1000 -> final o_dac_data = 16'h0FA0.
REQ-041 i_dac_done withheld -> o_timeout_err=1 after 4096 cycles, state IDLE, o_dac_value unchanged.
REQ-042 Reset asserted during WAIT_DONE, then a done pulse -> no state change, all outputs at reset values.
REQ-043 HV_DAC_RAMP_EN undefined, o_dac_value=0, host 350 -> exactly one write of 350.
